// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one fixed-latency ALU between NREQ requesters.
// Each accepted operation returns exactly one tagged response on RSP_*, unless reset intervenes first.
module alu_req_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int CW   = 4,
  parameter int LAT  = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      REQ_VALID,
  output logic [NREQ-1:0]      REQ_READY,
  input  logic [NREQ*DW-1:0]   REQ_OPA,
  input  logic [NREQ*DW-1:0]   REQ_OPB,
  input  logic [NREQ-1:0]      REQ_CIN,
  input  logic [NREQ*CW-1:0]   REQ_CMD,
  input  logic [NREQ-1:0]      REQ_MODE,
  input  logic [NREQ*2-1:0]    REQ_INP_VALID,
  output logic                 ALU_CE,
  output logic [1:0]           ALU_INP_VALID,
  output logic [DW-1:0]        ALU_OPA,
  output logic [DW-1:0]        ALU_OPB,
  output logic                 ALU_CIN,
  output logic [CW-1:0]        ALU_CMD,
  output logic                 ALU_MODE,
  input  logic [2*DW-1:0]      ALU_RES,
  input  logic                 ALU_COUT,
  input  logic                 ALU_OFLOW,
  input  logic                 ALU_G,
  input  logic                 ALU_E,
  input  logic                 ALU_L,
  input  logic                 ALU_ERR,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [$clog2(NREQ)-1:0] RSP_ID,
  output logic [2*DW-1:0]      RSP_RES,
  output logic                 RSP_COUT,
  output logic                 RSP_OFLOW,
  output logic                 RSP_G,
  output logic                 RSP_E,
  output logic                 RSP_L,
  output logic                 RSP_ERR,
  output logic                 BUSY,
  output logic [1:0]           DBG_STATE
);

  localparam int PW   = $clog2(NREQ);
  localparam int CNTW = (LAT > 1) ? $clog2(LAT) : 1;

  // Handshakes: a transfer happens on the rising CLK edge where valid and ready are both high;
  // valid and payload must be held until that edge, and ready may depend combinationally on valid.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            alu_ce_q, alu_ce_d;
  logic [1:0]      alu_inp_valid_q, alu_inp_valid_d;
  logic [DW-1:0]   alu_opa_q, alu_opa_d, alu_opb_q, alu_opb_d;
  logic            alu_cin_q, alu_cin_d, alu_mode_q, alu_mode_d;
  logic [CW-1:0]   alu_cmd_q, alu_cmd_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [PW-1:0]   rsp_id_q, rsp_id_d;
  logic [2*DW-1:0] rsp_res_q, rsp_res_d;
  logic            rsp_cout_q, rsp_cout_d, rsp_oflow_q, rsp_oflow_d;
  logic            rsp_g_q, rsp_g_d, rsp_e_q, rsp_e_d, rsp_l_q, rsp_l_d;
  logic            rsp_err_q, rsp_err_d;

  logic            gnt_found;
  logic [PW-1:0]   gnt_id;
  int              scan_idx;
  logic [PW-1:0]   scan_id;
  logic [DW-1:0]   sel_opa, sel_opb;
  logic            sel_cin, sel_mode;
  logic [CW-1:0]   sel_cmd;
  logic [1:0]      sel_inp_valid;

  // Search starts at ptr_q so the most recently served requester is always considered last.
  always_comb begin : grant_search
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan_idx  = 0;
    scan_id   = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      scan_id = PW'(scan_idx);
      if (!gnt_found && REQ_VALID[scan_id]) begin
        gnt_found = 1'b1;
        gnt_id    = scan_id;
      end
    end
  end

  always_comb begin : payload_mux
    sel_opa       = '0;
    sel_opb       = '0;
    sel_cin       = 1'b0;
    sel_mode      = 1'b0;
    sel_cmd       = '0;
    sel_inp_valid = 2'b00;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == PW'(i)) begin
        sel_opa       = REQ_OPA[i*DW +: DW];
        sel_opb       = REQ_OPB[i*DW +: DW];
        sel_cin       = REQ_CIN[i];
        sel_mode      = REQ_MODE[i];
        sel_cmd       = REQ_CMD[i*CW +: CW];
        sel_inp_valid = REQ_INP_VALID[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin : fsm_state
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_found) state_d = (sel_inp_valid != 2'b00) ? S_ISSUE : S_RESP;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
      S_RESP:  if (RSP_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : fsm_out
    REQ_READY = '0;
    if (state_q == S_IDLE && RST && gnt_found) REQ_READY[gnt_id] = 1'b1;
    BUSY      = (state_q != S_IDLE);
    DBG_STATE = state_q;
  end

  always_comb begin : datapath_next
    ptr_d           = ptr_q;
    cnt_d           = cnt_q;
    alu_ce_d        = alu_ce_q;
    alu_inp_valid_d = alu_inp_valid_q;
    alu_opa_d       = alu_opa_q;
    alu_opb_d       = alu_opb_q;
    alu_cin_d       = alu_cin_q;
    alu_cmd_d       = alu_cmd_q;
    alu_mode_d      = alu_mode_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_id_d        = rsp_id_q;
    rsp_res_d       = rsp_res_q;
    rsp_cout_d      = rsp_cout_q;
    rsp_oflow_d     = rsp_oflow_q;
    rsp_g_d         = rsp_g_q;
    rsp_e_d         = rsp_e_q;
    rsp_l_d         = rsp_l_q;
    rsp_err_d       = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          rsp_id_d = gnt_id;
          if (sel_inp_valid != 2'b00) begin
            alu_ce_d        = 1'b1;
            alu_inp_valid_d = sel_inp_valid;
            alu_opa_d       = sel_opa;
            alu_opb_d       = sel_opb;
            alu_cin_d       = sel_cin;
            alu_cmd_d       = sel_cmd;
            alu_mode_d      = sel_mode;
          end else begin
            // No operand is valid: answer with an error without touching the ALU.
            rsp_valid_d = 1'b1;
            rsp_res_d   = '0;
            rsp_cout_d  = 1'b0;
            rsp_oflow_d = 1'b0;
            rsp_g_d     = 1'b0;
            rsp_e_d     = 1'b0;
            rsp_l_d     = 1'b0;
            rsp_err_d   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        alu_inp_valid_d = 2'b00;
        cnt_d           = CNTW'(LAT - 1);
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          alu_ce_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_res_d   = ALU_RES;
          rsp_cout_d  = ALU_COUT;
          rsp_oflow_d = ALU_OFLOW;
          rsp_g_d     = ALU_G;
          rsp_e_d     = ALU_E;
          rsp_l_d     = ALU_L;
          rsp_err_d   = ALU_ERR;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          ptr_d       = (rsp_id_q == PW'(NREQ - 1)) ? '0 : rsp_id_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin : datapath_regs
    if (!RST) begin
      ptr_q           <= '0;
      cnt_q           <= '0;
      alu_ce_q        <= 1'b0;
      alu_inp_valid_q <= 2'b00;
      alu_opa_q       <= '0;
      alu_opb_q       <= '0;
      alu_cin_q       <= 1'b0;
      alu_cmd_q       <= '0;
      alu_mode_q      <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_id_q        <= '0;
      rsp_res_q       <= '0;
      rsp_cout_q      <= 1'b0;
      rsp_oflow_q     <= 1'b0;
      rsp_g_q         <= 1'b0;
      rsp_e_q         <= 1'b0;
      rsp_l_q         <= 1'b0;
      rsp_err_q       <= 1'b0;
    end else begin
      ptr_q           <= ptr_d;
      cnt_q           <= cnt_d;
      alu_ce_q        <= alu_ce_d;
      alu_inp_valid_q <= alu_inp_valid_d;
      alu_opa_q       <= alu_opa_d;
      alu_opb_q       <= alu_opb_d;
      alu_cin_q       <= alu_cin_d;
      alu_cmd_q       <= alu_cmd_d;
      alu_mode_q      <= alu_mode_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_id_q        <= rsp_id_d;
      rsp_res_q       <= rsp_res_d;
      rsp_cout_q      <= rsp_cout_d;
      rsp_oflow_q     <= rsp_oflow_d;
      rsp_g_q         <= rsp_g_d;
      rsp_e_q         <= rsp_e_d;
      rsp_l_q         <= rsp_l_d;
      rsp_err_q       <= rsp_err_d;
    end
  end

  assign ALU_CE        = alu_ce_q;
  assign ALU_INP_VALID = alu_inp_valid_q;
  assign ALU_OPA       = alu_opa_q;
  assign ALU_OPB       = alu_opb_q;
  assign ALU_CIN       = alu_cin_q;
  assign ALU_CMD       = alu_cmd_q;
  assign ALU_MODE      = alu_mode_q;
  assign RSP_VALID     = rsp_valid_q;
  assign RSP_ID        = rsp_id_q;
  assign RSP_RES       = rsp_res_q;
  assign RSP_COUT      = rsp_cout_q;
  assign RSP_OFLOW     = rsp_oflow_q;
  assign RSP_G         = rsp_g_q;
  assign RSP_E         = rsp_e_q;
  assign RSP_L         = rsp_l_q;
  assign RSP_ERR       = rsp_err_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: stub ALU with fixed latency, directed requesters,
// scoreboard of hand-computed responses popped by an independent response monitor.
module tb_alu_req_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int CW   = 4;
  localparam int LAT  = 2;
  localparam int EW   = 3 + 2 + 16 + 2;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b0;
  logic [NREQ-1:0]      REQ_VALID = '0;
  logic [NREQ-1:0]      REQ_READY;
  logic [NREQ*DW-1:0]   REQ_OPA = '0;
  logic [NREQ*DW-1:0]   REQ_OPB = '0;
  logic [NREQ-1:0]      REQ_CIN = '0;
  logic [NREQ*CW-1:0]   REQ_CMD = '0;
  logic [NREQ-1:0]      REQ_MODE = '0;
  logic [NREQ*2-1:0]    REQ_INP_VALID = '0;
  logic                 ALU_CE;
  logic [1:0]           ALU_INP_VALID;
  logic [DW-1:0]        ALU_OPA, ALU_OPB;
  logic                 ALU_CIN, ALU_MODE;
  logic [CW-1:0]        ALU_CMD;
  logic [2*DW-1:0]      ALU_RES = '0;
  logic                 ALU_COUT = 1'b0, ALU_OFLOW = 1'b0, ALU_G = 1'b0;
  logic                 ALU_E = 1'b0, ALU_L = 1'b0, ALU_ERR = 1'b0;
  logic                 RSP_VALID;
  logic                 RSP_READY = 1'b0;
  logic [1:0]           RSP_ID;
  logic [2*DW-1:0]      RSP_RES;
  logic                 RSP_COUT, RSP_OFLOW, RSP_G, RSP_E, RSP_L, RSP_ERR;
  logic                 BUSY;
  logic [1:0]           DBG_STATE;

  alu_req_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CW), .LAT(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB), .REQ_CIN(REQ_CIN),
    .REQ_CMD(REQ_CMD), .REQ_MODE(REQ_MODE), .REQ_INP_VALID(REQ_INP_VALID),
    .ALU_CE(ALU_CE), .ALU_INP_VALID(ALU_INP_VALID),
    .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB), .ALU_CIN(ALU_CIN),
    .ALU_CMD(ALU_CMD), .ALU_MODE(ALU_MODE),
    .ALU_RES(ALU_RES), .ALU_COUT(ALU_COUT), .ALU_OFLOW(ALU_OFLOW),
    .ALU_G(ALU_G), .ALU_E(ALU_E), .ALU_L(ALU_L), .ALU_ERR(ALU_ERR),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
    .RSP_RES(RSP_RES), .RSP_COUT(RSP_COUT), .RSP_OFLOW(RSP_OFLOW),
    .RSP_G(RSP_G), .RSP_E(RSP_E), .RSP_L(RSP_L), .RSP_ERR(RSP_ERR),
    .BUSY(BUSY), .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and check helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (!ok) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(act === exp, name, act, exp);
  endtask

  // ---------------- stub ALU: result valid LAT edges after the sampling edge ----------------
  logic       s_ce = 1'b0;
  logic [1:0] s_iv = 2'b00;
  logic [7:0] s_opa = '0, s_opb = '0;
  logic       s_cin = 1'b0, s_mode = 1'b0;
  logic [3:0] s_cmd = '0;
  int         alu_cnt = 0;
  logic [15:0] alu_pend = '0;
  logic        alu_pcout = 1'b0;
  logic [8:0]  sum9;

  always @(negedge CLK) begin
    s_ce = ALU_CE; s_iv = ALU_INP_VALID; s_opa = ALU_OPA; s_opb = ALU_OPB;
    s_cin = ALU_CIN; s_mode = ALU_MODE; s_cmd = ALU_CMD;
  end

  always @(posedge CLK) begin
    #1;
    if (alu_cnt > 0) begin
      alu_cnt = alu_cnt - 1;
      if (alu_cnt == 0) begin
        ALU_RES  = alu_pend;
        ALU_COUT = alu_pcout;
      end
    end
    if (s_ce && s_iv != 2'b00) begin
      sum9 = {1'b0, s_opa} + {1'b0, s_opb} + {8'b0, s_cin};
      if (s_mode && s_cmd == 4'd0) begin
        alu_pend  = {7'b0, sum9};
        alu_pcout = sum9[8];
      end else begin
        alu_pend  = {s_opa, s_opb};
        alu_pcout = 1'b0;
      end
      ALU_G = (s_opa > s_opb); ALU_E = (s_opa == s_opb); ALU_L = (s_opa < s_opb);
      ALU_RES  = 16'hDEAD;
      ALU_COUT = 1'b1;
      alu_cnt  = LAT - 1;
    end
  end

  // ---------------- requester tables (hand-computed ADD results) ----------------
  logic [7:0]  opa_t [NREQ];
  logic [7:0]  opb_t [NREQ];
  logic [1:0]  iv_t  [NREQ];
  logic [15:0] res_t [NREQ];
  logic        cout_t[NREQ];
  logic [NREQ-1:0] hold_req = '0;
  bit          ce_seen = 1'b0;

  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  int            grant_log[$];
  int            grant_cyc[$];

  task automatic drive_payload();
    for (int i = 0; i < NREQ; i++) begin
      REQ_OPA[i*DW +: DW]      = opa_t[i];
      REQ_OPB[i*DW +: DW]      = opb_t[i];
      REQ_CMD[i*CW +: CW]      = 4'd0;
      REQ_MODE[i]              = 1'b1;
      REQ_CIN[i]               = 1'b0;
      REQ_INP_VALID[i*2 +: 2]  = iv_t[i];
    end
  endtask

  // One clock of the requester driver: log grants, push expected responses, drop served requests.
  task automatic step();
    logic [NREQ-1:0] gnt;
    @(negedge CLK);
    gnt = REQ_READY;
    chk_eq("ready_onehot", 32'($countones(gnt) <= 1), 32'd1);
    chk_eq("ready_without_valid", 32'(gnt & ~REQ_VALID), 32'd0);
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        if (iv_t[i] == 2'b00) exp_q.push_back({3'd1, 2'(i), 16'h0000, 1'b0, 1'b1});
        else                  exp_q.push_back({3'(LAT + 2), 2'(i), res_t[i], cout_t[i], 1'b0});
        acc_q.push_back(cyc);
        grant_log.push_back(i);
        grant_cyc.push_back(cyc);
      end
    end
    if (ALU_CE) ce_seen = 1'b1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i] && !hold_req[i]) REQ_VALID[i] = 1'b0;
  endtask

  task automatic wait_grant();
    int start;
    int n;
    start = grant_log.size();
    n = 0;
    while (grant_log.size() == start && n < 40) begin
      step();
      n++;
    end
    chk_eq("grant_seen", 32'(grant_log.size() > start), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || REQ_VALID != '0) && n < 200) begin
      step();
      n++;
    end
    chk_eq("drain_queue", 32'(exp_q.size()), 32'd0);
    step();
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    exp_q.delete(); acc_q.delete(); grant_log.delete(); grant_cyc.delete();
  endtask

  // ---------------- response monitor / scoreboard ----------------
  bit            prev_valid = 1'b0;
  logic [EW-1:0] exp_w;
  int            acc_c;

  always @(negedge CLK) begin
    if (!RST) begin
      prev_valid = 1'b0;
    end else begin
      if (RSP_VALID) begin
        chk_eq("rsp_req_ready_low", 32'(REQ_READY), 32'd0);
        chk_eq("rsp_alu_inp_valid_low", 32'(ALU_INP_VALID), 32'd0);
        if (!prev_valid) begin
          chk(exp_q.size() != 0, "rsp_expected", 32'(exp_q.size()), 32'd1);
          if (exp_q.size() != 0)
            chk_eq("rsp_latency", 32'(cyc - acc_q[0]), 32'(exp_q[0][22:20]));
        end
        if (RSP_READY && exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          acc_c = acc_q.pop_front();
          chk_eq("rsp_id", 32'(RSP_ID), 32'(exp_w[19:18]));
          chk_eq("rsp_res", 32'(RSP_RES), 32'(exp_w[17:2]));
          chk_eq("rsp_cout", 32'(RSP_COUT), 32'(exp_w[1]));
          chk_eq("rsp_err", 32'(RSP_ERR), 32'(exp_w[0]));
        end
      end
      prev_valid = RSP_VALID;
    end
  end

  // ---------------- directed stimulus ----------------
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    opa_t  = '{8'h01, 8'h0F, 8'hF0, 8'h33};
    opb_t  = '{8'h02, 8'h01, 8'h20, 8'h44};
    iv_t   = '{2'b11, 2'b11, 2'b11, 2'b11};
    res_t  = '{16'h0003, 16'h0010, 16'h0110, 16'h0077};
    cout_t = '{1'b0, 1'b0, 1'b1, 1'b0};
    drive_payload();

    // Reset values with every requester asking.
    REQ_VALID = 4'b1111;
    repeat (3) @(negedge CLK);
    chk_eq("reset_req_ready", 32'(REQ_READY), 32'd0);
    chk_eq("reset_busy", 32'(BUSY), 32'd0);
    chk_eq("reset_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk_eq("reset_alu_ce", 32'(ALU_CE), 32'd0);
    chk_eq("reset_alu_opa", 32'(ALU_OPA), 32'd0);
    chk_eq("reset_rsp_res", 32'(RSP_RES), 32'd0);
    chk_eq("reset_state", 32'(DBG_STATE), 32'd0);
    @(posedge CLK); #1;
    REQ_VALID = '0;
    RST = 1'b1;
    RSP_READY = 1'b1;

    // Single request from requester 1: 0x0F + 0x01.
    REQ_VALID = 4'b0010;
    wait_grant();
    chk_eq("single_grant_id", 32'(grant_log[$]), 32'd1);
    @(negedge CLK);
    chk_eq("issue_alu_ce", 32'(ALU_CE), 32'd1);
    chk_eq("issue_alu_inp_valid", 32'(ALU_INP_VALID), 32'd3);
    chk_eq("issue_alu_opa", 32'(ALU_OPA), 32'h0F);
    chk_eq("issue_alu_opb", 32'(ALU_OPB), 32'h01);
    chk_eq("issue_ready_low", 32'(REQ_READY), 32'd0);
    chk_eq("issue_busy", 32'(BUSY), 32'd1);
    drain();

    // All four requesting continuously from a fresh pointer.
    do_reset();
    hold_req  = 4'b1111;
    REQ_VALID = 4'b1111;
    for (int n = 0; n < 60 && grant_log.size() < 5; n++) step();
    REQ_VALID = '0;
    hold_req  = '0;
    chk_eq("rr_grant_count", 32'(grant_log.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      if (k < grant_log.size()) chk_eq("rr_grant_order", 32'(grant_log[k]), 32'(exp_order[k]));
    for (int k = 1; k < 5; k++)
      if (k < grant_cyc.size()) chk_eq("rr_grant_spacing", 32'(grant_cyc[k] - grant_cyc[k-1]), 32'(LAT + 3));
    drain();

    // Backpressure: response held for 10 cycles while requester 2 waits.
    RSP_READY = 1'b0;
    REQ_VALID = 4'b0001;
    for (int n = 0; n < 20 && !RSP_VALID; n++) step();
    REQ_VALID[2] = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge CLK);
      chk_eq("bp_rsp_valid", 32'(RSP_VALID), 32'd1);
      chk_eq("bp_rsp_res", 32'(RSP_RES), 32'h0003);
      chk_eq("bp_rsp_id", 32'(RSP_ID), 32'd0);
      chk_eq("bp_req_ready", 32'(REQ_READY), 32'd0);
      chk_eq("bp_alu_ce", 32'(ALU_CE), 32'd0);
    end
    @(posedge CLK); #1;
    RSP_READY = 1'b1;
    drain();

    // No valid operands from requester 2: immediate error response, ALU untouched.
    iv_t[2] = 2'b00;
    drive_payload();
    ce_seen = 1'b0;
    REQ_VALID = 4'b0100;
    drain();
    chk_eq("err_alu_ce_seen", 32'(ce_seen), 32'd0);
    iv_t[2] = 2'b11;
    drive_payload();

    // Asynchronous reset while waiting on the ALU.
    REQ_VALID = 4'b0010;
    wait_grant();
    step();
    chk_eq("wait_state", 32'(DBG_STATE), 32'd2);
    #2;
    RST = 1'b0;
    #1;
    chk_eq("async_alu_ce", 32'(ALU_CE), 32'd0);
    chk_eq("async_alu_opa", 32'(ALU_OPA), 32'd0);
    chk_eq("async_busy", 32'(BUSY), 32'd0);
    chk_eq("async_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk_eq("async_state", 32'(DBG_STATE), 32'd0);
    exp_q.delete(); acc_q.delete(); grant_log.delete(); grant_cyc.delete();
    @(posedge CLK); #1;
    REQ_VALID = 4'b1010;
    RST = 1'b1;
    #1;
    chk_eq("post_reset_rsp_valid", 32'(RSP_VALID), 32'd0);
    wait_grant();
    chk_eq("post_reset_first_grant", 32'(grant_log[0]), 32'd1);
    drain();
    chk_eq("post_reset_second_grant", 32'(grant_log.size() > 1 ? grant_log[1] : -1), 32'd3);

    // Requester 3 withdraws while requester 0 is served; 0 re-requests and wins next.
    do_reset();
    REQ_VALID = 4'b1001;
    wait_grant();
    REQ_VALID[3] = 1'b0;
    REQ_VALID[0] = 1'b1;
    drain();
    chk_eq("skip_grant_count", 32'(grant_log.size()), 32'd2);
    for (int k = 0; k < grant_log.size(); k++)
      chk_eq("skip_grant_id", 32'(grant_log[k]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
